instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
Other end of the main control decoder: builds 32-bit instruction words from mnemonic codes and fields, then writes them sequentially into instruction memory. The decoder later reads these words back as opcode/funct.
Sits between the testbench/boot-load interface and the instruction memory write port. Only active before the datapath runs.
Opcode and funct values are the same ones the main control decodes, so load and decode always agree.

Parameters:
ADDR_W, 8, instruction memory word-address width
BASE_ADDR, 0, first word address written after reset or clear
DEPTH, 256, number of writable words; at most 2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  sync pulse: address returns to BASE_ADDR, full/err/count cleared
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_mnem  in  4  mnemonic code: 0 add,1 sub,2 and,3 or,4 slt,5 brv,6 jmxor,7 lw,8 sw,9 beq,10 j,11 nandi,12 blezal,13 jalpc,14 baln,15 illegal
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shamt field
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded instruction word
count  out  ADDR_W+1  number of words written since reset/clear
full  out  1  DEPTH words written
err  out  1  sticky: illegal mnemonic seen, or request presented while full

Behaviour:
- Reset values: in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, state=IDLE.
- State machine has three states.
  - IDLE: in_ready=1 unless full. On handshake with a legal mnemonic: register the encoded word and go to WRITE.
  - WRITE: imem_we=1 for exactly one cycle, with imem_addr/imem_wdata stable and in_ready=0. Next cycle: address+1, count+1, state back to IDLE, or to FULL when count reaches DEPTH.
  - FULL: in_ready=0, full=1. A request seen while full sets err; nothing is written.
- Throughput is 1 word per 2 cycles. Latency from handshake to imem_we is 1 cycle.
- Illegal mnemonic (15): the handshake completes, err is set, no write occurs, and the address is unchanged.
- Encoding, with fields packed MSB→LSB:
  - R-format: {6'b000000, rs, rt, rd, shamt, funct}. Funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010, brv 010100, jmxor 100011.
  - I-format: {op, rs, rt, imm}. Opcodes: lw 100011, sw 101011, beq 000100, nandi 010000, blezal 100100, jalpc 011111.
  - J-format: {op, target}. Opcodes: j 000010, baln 011011.
  - Fields a format does not use are ignored, never masked into other bits.
- Address arithmetic: imem_addr wraps modulo 2**ADDR_W. full asserts when count==DEPTH, so with DEPTH=2**ADDR_W the address never writes over itself.
- clear:
  - Takes effect from any state and has priority over a same-cycle handshake; that request is dropped and not written.
  - If clear arrives in WRITE, the in-progress write still completes that cycle, then the counters reset.
- Reset asserted mid-WRITE: the write is aborted immediately; imem_we=0 asynchronously.

Decomposition:
- Shared package holds:
  - the opcode and funct constants, which the main control also uses;
  - the mnemonic code enum;
  - the format enum (R/I/J).
- One combinational sub-module, instr_encode, maps mnemonic plus fields to {word, legal}. The top level holds the FSM, address/count registers and handshake.

Test Plan:
- add rs=1 rt=2 rd=3 shamt=0 after reset → one imem_we pulse at addr 0 with wdata 0x00221820, count=1.
- brv rs=4 rt=0 rd=0, then jmxor rs=5 rt=6 rd=7, back to back → addr 0: 0x00800014, addr 1: 0x00A63823; in_ready low in every WRITE cycle.
- nandi rs=1 rt=2 imm=0xFFFF → 0x4022FFFF; baln target=0x0000040 → 0x6C000040; jalpc rs=0 rt=31 imm=0x0010 → 0x7C1F0010.
- Mnemonic 15 → no imem_we pulse, err=1, address stays 0; the next add is written at addr 0.
- DEPTH=4: five requests → four writes at addrs 0..3, full=1, in_ready=0, err=1 after the fifth request; clear → addr 0, count 0, full 0, err 0.
- Reset asserted during a WRITE cycle → imem_we drops at once, all outputs return to reset values, no pulse after reset releases.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-set constants: opcodes and funct codes common to the
// loader/encoder and the main control decoder, plus mnemonic, format and
// loader state types.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_NANDI  = 6'b010000;
  localparam logic [5:0] OP_BLEZAL = 6'b100100;
  localparam logic [5:0] OP_JALPC  = 6'b011111;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BALN   = 6'b011011;

  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_SLT    = 6'b101010;
  localparam logic [5:0] FN_BRV    = 6'b010100;
  localparam logic [5:0] FN_JMXOR  = 6'b100011;

  typedef enum logic [3:0] {
    MN_ADD    = 4'd0,  MN_SUB    = 4'd1,  MN_AND   = 4'd2,  MN_OR    = 4'd3,
    MN_SLT    = 4'd4,  MN_BRV    = 4'd5,  MN_JMXOR = 4'd6,  MN_LW    = 4'd7,
    MN_SW     = 4'd8,  MN_BEQ    = 4'd9,  MN_J     = 4'd10, MN_NANDI = 4'd11,
    MN_BLEZAL = 4'd12, MN_JALPC  = 4'd13, MN_BALN  = 4'd14, MN_ILLEGAL = 4'd15
  } mnem_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_NONE} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FULL} state_e;

  function automatic fmt_e mnem_fmt(input mnem_e m);
    case (m)
      MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT, MN_BRV, MN_JMXOR: mnem_fmt = FMT_R;
      MN_LW, MN_SW, MN_BEQ, MN_NANDI, MN_BLEZAL, MN_JALPC:      mnem_fmt = FMT_I;
      MN_J, MN_BALN:                                           mnem_fmt = FMT_J;
      default:                                                 mnem_fmt = FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Combinational encoder: mnemonic plus fields to a 32-bit instruction word.
// Fields unused by the selected format are dropped, never merged into the word.
module instr_encode
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  mnem_e      mnem;
  logic [5:0] op;
  logic [5:0] funct;

  assign mnem = mnem_e'(mnem_i);

  // Select opcode/funct, then pack fields according to the instruction format.
  always_comb begin
    op      = OP_RTYPE;
    funct   = 6'b000000;
    word_o  = 32'h0;
    legal_o = 1'b1;
    case (mnem)
      MN_ADD:    funct = FN_ADD;
      MN_SUB:    funct = FN_SUB;
      MN_AND:    funct = FN_AND;
      MN_OR:     funct = FN_OR;
      MN_SLT:    funct = FN_SLT;
      MN_BRV:    funct = FN_BRV;
      MN_JMXOR:  funct = FN_JMXOR;
      MN_LW:     op    = OP_LW;
      MN_SW:     op    = OP_SW;
      MN_BEQ:    op    = OP_BEQ;
      MN_NANDI:  op    = OP_NANDI;
      MN_BLEZAL: op    = OP_BLEZAL;
      MN_JALPC:  op    = OP_JALPC;
      MN_J:      op    = OP_J;
      MN_BALN:   op    = OP_BALN;
      default:   op    = OP_RTYPE;
    endcase
    case (mnem_fmt(mnem))
      FMT_R:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct};
      FMT_I:   word_o = {op, rs_i, rt_i, imm_i};
      FMT_J:   word_o = {op, target_i};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time instruction loader: accepts encode requests, writes the encoded
// words to sequential instruction-memory addresses, one word per two cycles.
//
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_WRITE | imem_we high for this single cycle, address/data held
//   ST_FULL  | DEPTH words written; requests only set err
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         enc_word;
  logic                enc_legal;

  instr_encode u_encode (
    .mnem_i   (in_mnem),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign err        = err_q;

  // State and datapath registers; reset also kills an in-flight write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_C;
      count_q <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshake and write strobe; clear beats a same-cycle request.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (clear) begin
          addr_d  = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
        end else if (in_valid) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        if (clear) begin
          addr_d  = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = ((count_q + 1'b1) == DEPTH_C) ? ST_FULL : ST_IDLE;
        end
      end
      ST_FULL: begin
        if (clear) begin
          addr_d  = BASE_C;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (in_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
